// File: rtl/imm_prefix_extender.sv
// Immediate generator: widens an instruction immediate to the datapath width and
// splices a pending PREFIX payload onto the next retiring instruction's immediate.
//
// state (r_pfx_pending) | meaning
// ----------------------+-------------------------------------------------
// 0                     | no prefix held; immediates are plain extensions
// 1                     | pfx_reg valid; applied to next retiring instr
module imm_prefix_extender #(
    parameter int IMM_W  = 4,
    parameter int DATA_W = 16,
    parameter int PFX_W  = 12,
    parameter int SHIFT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic              pfx_load,
    input  logic [PFX_W-1:0]  pfx_data,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [1:0]        imm_mode,
    input  logic              flush,
    output logic [DATA_W-1:0] imm_out,
    output logic              pfx_pending,
    output logic              pfx_dbl
);

    generate
        if (PFX_W != DATA_W - IMM_W) begin : g_bad_pfx_w
            $fatal(1, "imm_prefix_extender: PFX_W must equal DATA_W-IMM_W");
        end
        if (SHIFT < 0 || SHIFT >= DATA_W) begin : g_bad_shift
            $fatal(1, "imm_prefix_extender: SHIFT out of range");
        end
    endgenerate

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    logic [PFX_W-1:0]  r_pfx_reg;
    logic              r_pfx_pending;
    logic              r_pfx_dbl;

    logic [PFX_W-1:0]  w_pfx_reg_nxt;
    logic              w_pfx_pending_nxt;
    logic              w_pfx_dbl_nxt;

    logic              w_use_pfx;
    logic              w_pfx_fire;
    logic              w_consume;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_spliced;
    logic [DATA_W-1:0] w_base;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pfx_reg     <= '0;
            r_pfx_pending <= 1'b0;
            r_pfx_dbl     <= 1'b0;
        end else begin
            r_pfx_reg     <= w_pfx_reg_nxt;
            r_pfx_pending <= w_pfx_pending_nxt;
            r_pfx_dbl     <= w_pfx_dbl_nxt;
        end
    end

    assign w_pfx_fire = instr_valid & pfx_load;
    assign w_consume  = instr_valid & ~pfx_load;

    // Next state; flush wins over a coincident PREFIX, a stall holds the prefix
    always_comb begin
        w_pfx_reg_nxt     = r_pfx_reg;
        w_pfx_pending_nxt = r_pfx_pending;
        w_pfx_dbl_nxt     = 1'b0;
        if (flush) begin
            w_pfx_pending_nxt = 1'b0;
        end else if (w_pfx_fire) begin
            w_pfx_reg_nxt     = pfx_data;
            w_pfx_pending_nxt = 1'b1;
            w_pfx_dbl_nxt     = r_pfx_pending;
        end else if (w_consume) begin
            w_pfx_pending_nxt = 1'b0;
        end
    end

    // Output logic; the prefix is masked during reset so it never leaks into that cycle
    assign w_use_pfx = r_pfx_pending & ~rst;
    assign w_sext    = {{PFX_W{imm_in[IMM_W-1]}}, imm_in};
    assign w_zext    = {{PFX_W{1'b0}}, imm_in};
    assign w_upper   = {imm_in, {PFX_W{1'b0}}};
    assign w_spliced = {r_pfx_reg, imm_in};

    always_comb begin
        w_base = w_sext;
        if (w_use_pfx) begin
            w_base = w_spliced;
        end else begin
            case (imm_mode)
                MODE_SEXT:   w_base = w_sext;
                MODE_ZEXT:   w_base = w_zext;
                MODE_BRANCH: w_base = w_sext;
                MODE_UPPER:  w_base = w_upper;
                default:     w_base = w_sext;
            endcase
        end
        imm_out = (imm_mode == MODE_BRANCH) ? (w_base << SHIFT) : w_base;
    end

    assign pfx_pending = r_pfx_pending;
    assign pfx_dbl     = r_pfx_dbl;

endmodule

// File: tb/tb_imm_prefix_extender.sv
// Directed bench for imm_prefix_extender: expected values are queued when stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_imm_prefix_extender;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        pfx_load;
    logic [11:0] pfx_data;
    logic [3:0]  imm_in;
    logic [1:0]  imm_mode;
    logic        flush;
    logic [15:0] imm_out;
    logic        pfx_pending;
    logic        pfx_dbl;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    imm_prefix_extender #(.IMM_W(4), .DATA_W(16), .PFX_W(12), .SHIFT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .pfx_load    (pfx_load),
        .pfx_data    (pfx_data),
        .imm_in      (imm_in),
        .imm_mode    (imm_mode),
        .flush       (flush),
        .imm_out     (imm_out),
        .pfx_pending (pfx_pending),
        .pfx_dbl     (pfx_dbl)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic pl, input logic [11:0] pd,
                         input logic [3:0] imm, input logic [1:0] md, input logic fl);
        rst         = r;
        instr_valid = iv;
        pfx_load    = pl;
        pfx_data    = pd;
        imm_in      = imm;
        imm_mode    = md;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic pend, input logic dbl);
        push({tag, "_pend"}, {15'd0, pend});
        check({15'd0, pfx_pending});
        push({tag, "_dbl"}, {15'd0, dbl});
        check({15'd0, pfx_dbl});
    endtask

    task automatic do_prefix(input logic [11:0] pd);
        drive(1'b0, 1'b1, 1'b1, pd, 4'h0, 2'b00, 1'b0);
        tick();
    endtask

    logic [15:0] mode_exp [4];

    initial begin
        mode_exp[0] = 16'hFFFA;
        mode_exp[1] = 16'h000A;
        mode_exp[2] = 16'hFFF4;
        mode_exp[3] = 16'hA000;

        // reset
        drive(1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 2'b00, 1'b0);
        @(posedge clk); #1;
        tick();
        push("rst_imm", 16'h0000); check(imm_out);
        chk_state("rst", 1'b0, 1'b0);

        // plain extension modes
        for (int m = 0; m < 4; m++) begin
            drive(1'b0, (m % 2) == 1, 1'b0, 12'hFFF, 4'hA, m[1:0], 1'b0);
            push($sformatf("noprefix_mode%0d", m), mode_exp[m]);
            check(imm_out);
        end
        tick();
        chk_state("noprefix", 1'b0, 1'b0);

        // prefix then immediate consume
        do_prefix(12'h123);
        chk_state("pfx1", 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        push("consume_1234", 16'h1234); check(imm_out);
        tick();
        chk_state("consumed", 1'b0, 1'b0);
        push("after_consume", 16'h0004); check(imm_out);
        tick();

        // prefix survives a stall
        do_prefix(12'h123);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
            tick();
            push($sformatf("stall%0d_pend", i), 16'h0001); check({15'd0, pfx_pending});
        end
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        push("stall_consume", 16'h1234); check(imm_out);
        tick();

        // branch mode with prefix, truncation
        do_prefix(12'h800);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h1, 2'b10, 1'b0);
        push("pfx_branch", 16'h0002); check(imm_out);
        tick();

        // upper mode with prefix uses the splice
        do_prefix(12'h5A5);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h3, 2'b11, 1'b0);
        push("pfx_upper", 16'h5A53); check(imm_out);
        tick();

        // back-to-back prefixes
        do_prefix(12'h111);
        chk_state("dbl_first", 1'b1, 1'b0);
        do_prefix(12'h222);
        chk_state("dbl_second", 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        tick();
        chk_state("dbl_after", 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        push("dbl_consume", 16'h2224); check(imm_out);
        tick();

        // flush discards a pending prefix
        do_prefix(12'h123);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 4'h4, 2'b00, 1'b1);
        tick();
        chk_state("flush", 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        push("flush_next", 16'h0004); check(imm_out);
        tick();

        // flush beats a coincident prefix, including an overwriting one
        do_prefix(12'h321);
        drive(1'b0, 1'b1, 1'b1, 12'hABC, 4'h4, 2'b00, 1'b1);
        tick();
        chk_state("flush_pfx", 1'b0, 1'b0);

        // flush with a consuming instruction still sees the prefix
        do_prefix(12'h123);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h4, 2'b00, 1'b1);
        push("flush_consume", 16'h1234); check(imm_out);
        tick();
        chk_state("flush_consume", 1'b0, 1'b0);

        // reset with a pending prefix
        do_prefix(12'h123);
        drive(1'b1, 1'b0, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        push("rst_masks_pfx", 16'h0004); check(imm_out);
        tick();
        drive(1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 2'b00, 1'b0);
        push("post_rst_imm", 16'h0000); check(imm_out);
        chk_state("post_rst", 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 4'h4, 2'b00, 1'b0);
        push("post_rst_instr", 16'h0004); check(imm_out);
        tick();

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries remain, 0 required", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
